quad_encoder_ext: RTL and testbench

//  Parametrised quadrature encoder interface: synchronises and glitch-filters A/B/I, decodes x4 counts,

---
 rtl/quad_encoder_ext.sv | 191 +++++++++++++++++++
 tb/tb_quad_encoder_ext.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_ext.sv
// Quadrature encoder front end: synchronises and filters A/B/I, decodes x4 position,
// handles the index pulse per runtime mode, flags illegal transitions and measures step period.
module quad_encoder_ext #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int PER_W       = 24,
    parameter bit INVERT_DIR  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             quad_i,
    input  logic [1:0]       index_mode,
    input  logic             index_arm,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             step,
    output logic [CNT_W-1:0] index_pos,
    output logic             index_seen,
    output logic             armed,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic [PER_W-1:0] edge_period
);

    localparam int RUN_W = $clog2(FILT_LEN + 1);

    typedef enum logic [1:0] {
        IDX_IGNORE      = 2'd0,
        IDX_CLEAR_ALL   = 2'd1,
        IDX_CLEAR_ARMED = 2'd2,
        IDX_LATCH       = 2'd3
    } idx_mode_e;

    // Bit order in the per-input vectors: [0] = A, [1] = B, [2] = I.
    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [2:0]                  filt_q, filt_d;
    logic [2:0]                  prev_q, prev_d;
    logic [2:0][RUN_W-1:0]       run_q, run_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        dir_q, dir_d;
    logic                        step_q, step_d;
    logic [CNT_W-1:0]            index_pos_q, index_pos_d;
    logic                        index_seen_q, index_seen_d;
    logic                        armed_q, armed_d;
    logic                        err_q, err_d;
    logic [7:0]                  err_cnt_q, err_cnt_d;
    logic [PER_W-1:0]            per_cnt_q, per_cnt_d;
    logic [PER_W-1:0]            edge_period_q, edge_period_d;

    logic [2:0]       sync_out;
    logic [1:0]       ph_diff;
    logic             fwd, rev, illegal, step_up, step_dn;
    logic             index_rise, index_clear, arm_pending;
    logic [CNT_W-1:0] stepped;
    logic [PER_W-1:0] per_inc;
    idx_mode_e        mode;

    // Gray position of {A,B}: 00 -> 0, 10 -> 1, 11 -> 2, 01 -> 3.
    function automatic logic [1:0] phase_of(input logic a, input logic b);
        return {b, a ^ b};
    endfunction

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        sync_d[0] = {quad_i, quad_b, quad_a};
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        sync_out = sync_q[SYNC_STAGES-1];

        // A differing run of FILT_LEN samples moves the filtered level; any match restarts it.
        filt_d = filt_q;
        for (int k = 0; k < 3; k++) begin
            run_d[k] = '0;
            if (sync_out[k] != filt_q[k]) begin
                if (run_q[k] == RUN_W'(FILT_LEN - 1)) begin
                    filt_d[k] = sync_out[k];
                end else begin
                    run_d[k] = run_q[k] + RUN_W'(1);
                end
            end
        end
        prev_d = filt_q;

        ph_diff = phase_of(filt_q[0], filt_q[1]) - phase_of(prev_q[0], prev_q[1]);
        fwd     = (ph_diff == 2'd1);
        rev     = (ph_diff == 2'd3);
        illegal = (ph_diff == 2'd2);
        step_up = INVERT_DIR ? rev : fwd;
        step_dn = INVERT_DIR ? fwd : rev;

        stepped = count_q;
        if (step_up) begin
            stepped = count_q + CNT_W'(1);
        end else if (step_dn) begin
            stepped = count_q - CNT_W'(1);
        end

        mode        = idx_mode_e'(index_mode);
        index_rise  = filt_q[2] & ~prev_q[2];
        arm_pending = armed_q | index_arm;
        index_clear = index_rise &&
                      ((mode == IDX_CLEAR_ALL) || ((mode == IDX_CLEAR_ARMED) && arm_pending));

        count_d = stepped;
        if (clear || index_clear) begin
            count_d = '0;
        end

        armed_d = arm_pending;
        if (clear || (index_rise && (mode == IDX_CLEAR_ARMED))) begin
            armed_d = 1'b0;
        end

        index_pos_d = index_pos_q;
        if (index_rise && (mode != IDX_IGNORE)) begin
            index_pos_d = stepped;
        end
        index_seen_d = index_rise;

        step_d = step_up | step_dn;
        dir_d  = (step_up | step_dn) ? step_up : dir_q;

        err_d     = clear ? 1'b0 : (err_q | illegal);
        err_cnt_d = err_cnt_q;
        if (clear) begin
            err_cnt_d = '0;
        end else if (illegal && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        // Illegal transitions leave the period counter running.
        per_inc       = (&per_cnt_q) ? per_cnt_q : per_cnt_q + PER_W'(1);
        per_cnt_d     = per_inc;
        edge_period_d = edge_period_q;
        if (step_up | step_dn) begin
            edge_period_d = per_inc;
            per_cnt_d     = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q        <= '0;
            filt_q        <= '0;
            prev_q        <= '0;
            run_q         <= '0;
            count_q       <= '0;
            dir_q         <= 1'b0;
            step_q        <= 1'b0;
            index_pos_q   <= '0;
            index_seen_q  <= 1'b0;
            armed_q       <= 1'b0;
            err_q         <= 1'b0;
            err_cnt_q     <= '0;
            per_cnt_q     <= '0;
            edge_period_q <= '0;
        end else begin
            sync_q        <= sync_d;
            filt_q        <= filt_d;
            prev_q        <= prev_d;
            run_q         <= run_d;
            count_q       <= count_d;
            dir_q         <= dir_d;
            step_q        <= step_d;
            index_pos_q   <= index_pos_d;
            index_seen_q  <= index_seen_d;
            armed_q       <= armed_d;
            err_q         <= err_d;
            err_cnt_q     <= err_cnt_d;
            per_cnt_q     <= per_cnt_d;
            edge_period_q <= edge_period_d;
        end
    end

    assign count       = count_q;
    assign dir         = dir_q;
    assign step        = step_q;
    assign index_pos   = index_pos_q;
    assign index_seen  = index_seen_q;
    assign armed       = armed_q;
    assign err         = err_q;
    assign err_cnt     = err_cnt_q;
    assign edge_period = edge_period_q;

endmodule

// File: tb/tb_quad_encoder_ext.sv
// Scoreboard bench for quad_encoder_ext: stimulus pushes expected step/index events,
// a negedge monitor pops and compares them whenever the DUT pulses step or index_seen.
`timescale 1ns/1ps
module tb_quad_encoder_ext;

    logic        clk = 1'b0;
    logic        reset;
    logic        quad_a, quad_b, quad_i;
    logic [1:0]  index_mode;
    logic        index_arm, clear;
    logic [31:0] count, index_pos;
    logic        dir, step, index_seen, armed, err;
    logic [7:0]  err_cnt;
    logic [23:0] edge_period;

    quad_encoder_ext dut (
        .clk(clk), .reset(reset), .quad_a(quad_a), .quad_b(quad_b), .quad_i(quad_i),
        .index_mode(index_mode), .index_arm(index_arm), .clear(clear),
        .count(count), .dir(dir), .step(step), .index_pos(index_pos),
        .index_seen(index_seen), .armed(armed), .err(err), .err_cnt(err_cnt),
        .edge_period(edge_period)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] cnt; logic dir; int per; } step_exp_t;
    typedef struct { logic [31:0] pos; logic [31:0] cnt; } idx_exp_t;

    step_exp_t   step_q[$];
    idx_exp_t    idx_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cur_phase = 0;
    logic [31:0] exp_count = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every step / index_seen pulse against the oldest expectation.
    always @(negedge clk) begin
        step_exp_t se;
        idx_exp_t  ie;
        if (!reset) begin
            if (step) begin
                if (step_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_step: got step with count %0h expected no step", count);
                end else begin
                    se = step_q.pop_front();
                    check("step_count", count, se.cnt);
                    check("step_dir", dir, se.dir);
                    if (se.per >= 0) check("edge_period", edge_period, se.per);
                end
            end
            if (index_seen) begin
                if (idx_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_index: got index_seen expected none");
                end else begin
                    ie = idx_q.pop_front();
                    check("index_pos", index_pos, ie.pos);
                    check("index_count", count, ie.cnt);
                end
            end
        end
    end

    function automatic logic [1:0] ab_of(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic move_raw(input bit up);
        cur_phase = up ? (cur_phase + 1) % 4 : (cur_phase + 3) % 4;
        {quad_a, quad_b} = ab_of(cur_phase);
    endtask

    task automatic move(input bit up, input int hold, input int per);
        move_raw(up);
        exp_count = up ? exp_count + 32'd1 : exp_count - 32'd1;
        step_q.push_back('{exp_count, up, per});
        wait_cyc(hold);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        wait_cyc(1);
        clear = 1'b0;
        exp_count = '0;
    endtask

    task automatic index_pulse();
        quad_i = 1'b1;
        wait_cyc(10);
        quad_i = 1'b0;
        wait_cyc(10);
    endtask

    initial begin
        reset = 1'b1; quad_a = 1'b0; quad_b = 1'b0; quad_i = 1'b0;
        index_mode = 2'd0; index_arm = 1'b0; clear = 1'b0;
        wait_cyc(3);
        check("rst_count", count, 0);
        check("rst_dir", dir, 0);
        check("rst_step", step, 0);
        check("rst_index_pos", index_pos, 0);
        check("rst_index_seen", index_seen, 0);
        check("rst_armed", armed, 0);
        check("rst_err", err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_edge_period", edge_period, 0);
        reset = 1'b0;
        wait_cyc(2);

        // 25 full up cycles = 100 x4 steps, 20 clocks per phase.
        for (int i = 0; i < 100; i++) move(1'b1, 20, (i == 0) ? -1 : 20);
        wait_cyc(10);
        check("t1_count", count, 100);
        check("t1_dir", dir, 1);
        check("t1_period", edge_period, 20);

        // Wrap both ways around zero.
        pulse_clear();
        check("t2_clear_count", count, 0);
        move(1'b0, 10, -1);
        check("t2_wrap_down", count, 32'hFFFF_FFFF);
        check("t2_dir_down", dir, 0);
        move(1'b1, 10, 10);
        check("t2_wrap_up", count, 0);

        // 3-cycle glitch rejected; 4-cycle pulse gives +1 then -1 four clocks apart.
        quad_a = 1'b1; wait_cyc(3); quad_a = 1'b0; wait_cyc(12);
        check("t3_glitch_count", count, exp_count);
        step_q.push_back('{exp_count + 32'd1, 1'b1, -1});
        quad_a = 1'b1; wait_cyc(4);
        step_q.push_back('{exp_count, 1'b0, 4});
        quad_a = 1'b0; wait_cyc(12);
        check("t3_pulse_count", count, exp_count);

        // Illegal transitions: both bits toggle together.
        {quad_a, quad_b} = 2'b11; cur_phase = 2; wait_cyc(10);
        check("t4_err", err, 1);
        check("t4_err_cnt", err_cnt, 1);
        check("t4_count", count, exp_count);
        for (int i = 0; i < 300; i++) begin
            {quad_a, quad_b} = ~{quad_a, quad_b};
            cur_phase = (cur_phase + 2) % 4;
            wait_cyc(6);
        end
        wait_cyc(4);
        check("t4_err_cnt_sat", err_cnt, 255);
        check("t4_count_hold", count, exp_count);
        pulse_clear();
        check("t4_err_clr", err, 0);
        check("t4_err_cnt_clr", err_cnt, 0);

        // Mode 1: index latches pre-clear value and clears count.
        index_mode = 2'd1;
        for (int i = 0; i < 57; i++) move(1'b1, 8, (i == 0) ? -1 : 8);
        check("t5_count57", count, 57);
        idx_q.push_back('{32'd57, 32'd0});
        index_pulse();
        exp_count = '0;
        check("t5_m1_count", count, 0);
        check("t5_m1_pos", index_pos, 57);

        // Mode 2: no clear without arm, clear once armed.
        index_mode = 2'd2;
        for (int i = 0; i < 3; i++) move(1'b1, 8, (i == 0) ? -1 : 8);
        idx_q.push_back('{32'd3, 32'd3});
        index_pulse();
        check("t5_m2_noarm_count", count, 3);
        check("t5_m2_noarm_armed", armed, 0);
        index_arm = 1'b1; wait_cyc(1); index_arm = 1'b0;
        check("t5_armed_set", armed, 1);
        idx_q.push_back('{32'd3, 32'd0});
        index_pulse();
        exp_count = '0;
        check("t5_m2_count", count, 0);
        check("t5_m2_armed", armed, 0);

        // Mode 0: pulse only, no latch, no clear.
        index_mode = 2'd0;
        move(1'b1, 8, -1);
        idx_q.push_back('{32'd3, 32'd1});
        index_pulse();
        check("t5_m0_count", count, 1);
        check("t5_m0_pos", index_pos, 3);

        // Index coincident with an up step in mode 1.
        index_mode = 2'd1;
        move_raw(1'b1);
        quad_i = 1'b1;
        idx_q.push_back('{exp_count + 32'd1, 32'd0});
        step_q.push_back('{32'd0, 1'b1, -1});
        exp_count = '0;
        wait_cyc(10);
        check("t6_coinc_count", count, 0);
        quad_i = 1'b0;
        wait_cyc(10);

        // Mid-operation reset with a step in flight.
        move(1'b1, 8, -1);
        while (cur_phase != 0) move(1'b1, 8, -1);
        index_arm = 1'b1; wait_cyc(1); index_arm = 1'b0;
        check("t6_pre_armed", armed, 1);
        move_raw(1'b1);
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(1);
        check("t6_rst_count", count, 0);
        check("t6_rst_dir", dir, 0);
        check("t6_rst_step", step, 0);
        check("t6_rst_index_pos", index_pos, 0);
        check("t6_rst_index_seen", index_seen, 0);
        check("t6_rst_armed", armed, 0);
        check("t6_rst_err", err, 0);
        check("t6_rst_err_cnt", err_cnt, 0);
        check("t6_rst_edge_period", edge_period, 0);
        exp_count = 32'd1;
        step_q.push_back('{32'd1, 1'b1, -1});
        reset = 1'b0;
        wait_cyc(6);
        check("t6_latency_early", count, 0);
        wait_cyc(1);
        check("t6_latency_step", step, 1);
        check("t6_latency_count", count, 1);

        wait_cyc(20);
        check("step_queue_empty", step_q.size(), 0);
        check("index_queue_empty", idx_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
